// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one source bit per clock.
// Saturates to all nines on overflow and reports a leading-zero blanking mask.
module seq_bin_to_bcd #(
    parameter int IN_W   = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank_mask
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [IN_W-1:0]    src_reg;
    logic [BCD_W-1:0]   scratch_reg;
    logic [BCD_W-1:0]   adj;
    logic               ovf_sticky_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic               overflow_reg;
    logic [DIGITS-1:0]  mask_reg;
    logic [BCD_W-1:0]   final_bcd;
    logic [DIGITS-1:0]  mask_next;

    // Per-digit add-3 correction; no carry crosses a digit boundary.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                  ? scratch_reg[4*gi +: 4] + 4'd3
                                  : scratch_reg[4*gi +: 4];
        end
    endgenerate

    assign final_bcd = ovf_sticky_reg ? {DIGITS{4'h9}} : scratch_reg;

    // Digit k blanks only when it and every digit above it are zero.
    assign mask_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_mask
            assign mask_next[gi] = ~|final_bcd[BCD_W-1:4*gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_reg        <= '0;
            scratch_reg    <= '0;
            ovf_sticky_reg <= 1'b0;
            cnt_reg        <= '0;
            bcd_reg        <= '0;
            overflow_reg   <= 1'b0;
            mask_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_reg        <= bin_in;
                        scratch_reg    <= '0;
                        ovf_sticky_reg <= 1'b0;
                        cnt_reg        <= CNT_W'(IN_W);
                    end
                end
                SHIFT: begin
                    scratch_reg <= {adj[BCD_W-2:0], src_reg[IN_W-1]};
                    src_reg     <= src_reg << 1;
                    cnt_reg     <= cnt_reg - CNT_W'(1);
                    if (adj[BCD_W-1]) begin
                        ovf_sticky_reg <= 1'b1;
                    end
                end
                DONE: begin
                    bcd_reg      <= final_bcd;
                    overflow_reg <= ovf_sticky_reg;
                    mask_reg     <= mask_next;
                end
                default: ;
            endcase
        end
    end

    assign bcd_out    = bcd_reg;
    assign overflow   = overflow_reg;
    assign blank_mask = mask_reg;

endmodule
